// File: rtl/rv32_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle control path: FSM state codes, opcodes,
// and the select encodings seen by the immediate generator, ALU and writeback mux.
package rv32_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST    = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_MEM    = 3'd4;
  localparam state_t ST_WB     = 3'd5;
  localparam state_t ST_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
  } imm_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2, ALU_PASSB = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_UPPER   = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_cls_t;

endpackage

// File: rtl/rv32_main_decoder.sv
// Combinational opcode classifier: instruction class and immediate format.
module rv32_main_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output instr_cls_t cls,
  output imm_sel_t   imm_sel
);

  // opcode -> class / immediate format
  always_comb begin
    cls     = CLS_ILLEGAL;
    imm_sel = IMM_I;
    case (opcode)
      OP_R, OP_IMM:     begin cls = CLS_ALU;     imm_sel = IMM_I; end
      OP_LOAD:          begin cls = CLS_LOAD;    imm_sel = IMM_I; end
      OP_STORE:         begin cls = CLS_STORE;   imm_sel = IMM_S; end
      OP_BRANCH:        begin cls = CLS_BRANCH;  imm_sel = IMM_B; end
      OP_JAL:           begin cls = CLS_JUMP;    imm_sel = IMM_J; end
      OP_JALR:          begin cls = CLS_JUMP;    imm_sel = IMM_I; end
      OP_LUI, OP_AUIPC: begin cls = CLS_UPPER;   imm_sel = IMM_U; end
      default:          begin cls = CLS_ILLEGAL; imm_sel = IMM_I; end
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM sharing one variable-latency memory port.
// Optional CTRL_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t     state;
  state_t     state_nxt;
  logic [TW-1:0] wait_cnt;
  logic [6:0] opcode;
  instr_cls_t cls;
  imm_sel_t   dec_imm;
  alu_op_t    dec_alu_op;
  logic       timeout;
  logic       instr_unused;

  assign opcode       = instr[6:0];
  assign instr_unused = ^instr[31:7];
  // Last permitted waiting cycle: completing now still wins over the timeout.
  assign timeout      = (wait_cnt == TW'(MEM_TIMEOUT - 1));

  rv32_main_decoder u_dec (
    .opcode  (opcode),
    .cls     (cls),
    .imm_sel (dec_imm)
  );

  // ALU operation implied by the instruction class
  always_comb begin
    dec_alu_op = ALU_ADD;
    case (cls)
      CLS_ALU:    dec_alu_op = ALU_FUNCT;
      CLS_BRANCH: dec_alu_op = ALU_SUB;
      CLS_UPPER:  dec_alu_op = (opcode == OP_LUI) ? ALU_PASSB : ALU_ADD;
      default:    dec_alu_op = ALU_ADD;
    endcase
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:    state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    state_nxt = ST_DECODE;
        else if (timeout) state_nxt = ST_TRAP;
        else              state_nxt = ST_FETCH;
      end
      ST_DECODE: state_nxt = (cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          CLS_BRANCH:          state_nxt = ST_FETCH;
          default:             state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)    state_nxt = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout) state_nxt = ST_TRAP;
        else              state_nxt = ST_MEM;
      end
      ST_WB:     state_nxt = ST_FETCH;
      ST_TRAP:   state_nxt = ST_TRAP;
      default:   state_nxt = ST_TRAP;
    endcase
  end

  // state register and memory wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RST;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (state == ST_FETCH || state == ST_MEM)
        wait_cnt <= wait_cnt + TW'(1);
      else
        wait_cnt <= wait_cnt;
    end
  end

  // Moore outputs, with the completion handshakes and branch decision folded in
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    imm_sel      = IMM_I;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    trap         = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      ST_DECODE: begin
        imm_sel = dec_imm;
        alu_op  = dec_alu_op;
      end
      ST_EXEC: begin
        imm_sel = dec_imm;
        alu_op  = dec_alu_op;
        case (cls)
          CLS_ALU:             alu_src_b = (opcode == OP_IMM);
          CLS_LOAD, CLS_STORE: alu_src_b = 1'b1;
          CLS_BRANCH: begin
            pc_we  = br_taken;
            pc_src = 1'b1;
          end
          CLS_JUMP: begin
            pc_we     = 1'b1;
            pc_src    = 1'b1;
            alu_src_a = (opcode == OP_JAL);
            alu_src_b = 1'b1;
          end
          CLS_UPPER: begin
            alu_src_a = (opcode == OP_AUIPC);
            alu_src_b = 1'b1;
          end
          default: alu_src_b = 1'b0;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == CLS_STORE);
      end
      ST_WB: begin
        reg_we = 1'b1;
        if (cls == CLS_LOAD)      wb_sel = WB_MEM;
        else if (cls == CLS_JUMP) wb_sel = WB_PC4;
        else                      wb_sel = WB_ALU;
      end
      ST_TRAP: trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  // cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != ST_RST && state != ST_TRAP)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      else
        cycle_cnt <= cycle_cnt;
      if (state_nxt == ST_FETCH && (state == ST_WB || state == ST_EXEC || state == ST_MEM))
        instret_cnt <= instret_cnt + CNT_W'(1);
      else
        instret_cnt <= instret_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Scoreboard bench for rv32_multicycle_ctrl: an instruction-level model expands
// each instruction into per-cycle stimulus and expected outputs.
module tb_rv32_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
  logic [2:0]  imm_sel;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        trap;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  rv32_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          rdy;
    bit          brt;
    logic [31:0] instr;
    logic [16:0] exp;
    string       tag;
    bit          chk;
    int          cyc;
    int          ins;
  } rec_t;

  rec_t        stim_q[$];
  rec_t        exp_q[$];
  int          m_cyc = 0;
  int          m_ins = 0;
  logic [31:0] cur_instr = 32'd0;
  int          checks = 0;
  int          failures = 0;

  localparam logic [16:0] TRAPV = 17'd1;

  function automatic logic [16:0] ov(bit req, bit we, bit as, bit irw, bit pcw, bit pcs,
                                     logic [2:0] imm, bit a, bit b, logic [1:0] op,
                                     bit rw, logic [1:0] wb, bit tr);
    return {req, we, as, irw, pcw, pcs, imm, a, b, op, rw, wb, tr};
  endfunction

  // kinds: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 illegal
  function automatic logic [6:0] k_opc(int k);
    case (k)
      0: return 7'b0110011;  1: return 7'b0010011;  2: return 7'b0000011;
      3: return 7'b0100011;  4: return 7'b1100011;  5: return 7'b1101111;
      6: return 7'b1100111;  7: return 7'b0110111;  8: return 7'b0010111;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [2:0] k_imm(int k);
    case (k)
      3: return 3'd1;  4: return 3'd2;  5: return 3'd4;  7, 8: return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] k_op(int k);
    case (k)
      0, 1: return 2'd2;  4: return 2'd1;  7: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic bit k_a(int k);  return (k == 5 || k == 8); endfunction
  function automatic bit k_b(int k);  return !(k == 0 || k == 4); endfunction

  function automatic logic [1:0] k_wb(int k);
    case (k)
      2: return 2'd1;  5, 6: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic bit rbit();
    return ($urandom_range(0, 1) != 0);
  endfunction

  task automatic add(input bit rst, input bit rdy, input bit brt, input string tag,
                     input logic [16:0] e, input bit act, input bit ret, input bit chk = 1'b1);
    rec_t r;
    r.rst_n = rst; r.rdy = rdy; r.brt = brt; r.instr = cur_instr; r.exp = e;
    r.tag = tag; r.chk = chk; r.cyc = m_cyc; r.ins = m_ins;
    stim_q.push_back(r);
    if (!rst) begin
      m_cyc = 0; m_ins = 0;
    end else begin
      if (act) m_cyc++;
      if (ret) m_ins++;
    end
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) add(1'b1, rbit(), rbit(), "trap", TRAPV, 1'b0, 1'b0);
  endtask

  // rst_n low for one edge in the current state, then one RST cycle
  task automatic do_reset(input string tag, input logic [16:0] e);
    add(1'b0, rbit(), rbit(), tag, e, 1'b0, 1'b0);
    add(1'b1, rbit(), rbit(), "rst_state", 17'd0, 1'b0, 1'b0);
  endtask

  task automatic run_instr(input int k, input logic [31:0] ins, input int fw, input int mw,
                           input int brt, input bit abort = 1'b0);
    bit          b;
    bit          isj;
    logic [16:0] me;
    cur_instr = ins;
    for (int i = 0; i < ((fw >= 15) ? 15 : fw); i++)
      add(1'b1, 1'b0, rbit(), "fetch_wait", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0), 1'b1, 1'b0);
    if (fw >= 15) begin
      trap_cycles(3);
      do_reset("fetch_timeout_rst", TRAPV);
      return;
    end
    add(1'b1, 1'b1, rbit(), "fetch_done", ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0), 1'b1, 1'b0);
    add(1'b1, rbit(), rbit(), "decode", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k_imm(k), 1'b0, 1'b0, k_op(k), 1'b0, 2'd0, 1'b0), 1'b1, 1'b0);
    if (k == 9) begin
      trap_cycles(3);
      do_reset("illegal_rst", TRAPV);
      return;
    end
    b   = (brt == 2) ? rbit() : (brt != 0);
    isj = (k == 5 || k == 6);
    add(1'b1, rbit(), b, "exec",
        ov(1'b0, 1'b0, 1'b0, 1'b0, (k == 4) ? b : isj, (k == 4) || isj, k_imm(k), k_a(k), k_b(k), k_op(k), 1'b0, 2'd0, 1'b0),
        1'b1, k == 4);
    if (k == 4) return;
    if (k == 2 || k == 3) begin
      me = ov(1'b1, k == 3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      if (abort) begin
        do_reset("mem_abort", me);
        return;
      end
      for (int i = 0; i < ((mw >= 15) ? 15 : mw); i++) add(1'b1, 1'b0, rbit(), "mem_wait", me, 1'b1, 1'b0);
      if (mw >= 15) begin
        trap_cycles(2);
        do_reset("mem_timeout_rst", TRAPV);
        return;
      end
      add(1'b1, 1'b1, rbit(), "mem_done", me, 1'b1, k == 3);
      if (k == 3) return;
    end
    add(1'b1, rbit(), rbit(), "wb", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, k_wb(k), 1'b0), 1'b1, 1'b1);
  endtask

  // build the program, then play it one record per cycle
  initial begin
    int          k, fw, mw;
    logic [31:0] r;
    rst_n = 1'b0; mem_ready = 1'b0; br_taken = 1'b0; instr = 32'd0;

    add(1'b0, 1'b0, 1'b0, "reset_assert", 17'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, rbit(), rbit(), "rst_state", 17'd0, 1'b0, 1'b0);
    run_instr(1, 32'h00C00093, 0, 0, 2);            // ADDI
    run_instr(3, 32'h00112623, 0, 3, 2);            // SW with 3 wait cycles
    run_instr(4, 32'h00208463, 0, 0, 0);            // BEQ not taken
    run_instr(4, 32'h00208463, 0, 0, 1);            // BEQ taken
    run_instr(9, 32'h0000007F, 0, 0, 2);            // illegal opcode
    run_instr(1, 32'h00C00093, 15, 0, 2);           // fetch timeout
    run_instr(0, 32'h002081B3, 14, 0, 2);           // ready on the 15th fetch cycle
    run_instr(2, 32'h0000A103, 0, 14, 2);           // LW ready on the 15th mem cycle
    run_instr(2, 32'h0000A103, 0, 15, 2);           // LW mem timeout
    run_instr(2, 32'h0000A103, 1, 0, 2, 1'b1);      // reset during MEM of LW
    run_instr(5, 32'h0080006F, 0, 0, 2);            // JAL
    run_instr(6, 32'h000080E7, 0, 0, 2);            // JALR
    run_instr(7, 32'h123450B7, 0, 0, 2);            // LUI
    run_instr(8, 32'h00001097, 0, 0, 2);            // AUIPC
    for (int n = 0; n < 250; n++) begin
      k  = $urandom_range(0, 8);
      r  = $urandom();
      fw = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      run_instr(k, {r[31:7], k_opc(k)}, fw, mw, 2);
    end
    run_instr(9, 32'h0000005B, 0, 0, 2);

    while (stim_q.size() > 0) begin
      rec_t s;
      s = stim_q.pop_front();
      @(posedge clk);
      #1;
      rst_n = s.rst_n; mem_ready = s.rdy; br_taken = s.brt; instr = s.instr;
      exp_q.push_back(s);
    end
    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected records never compared (want 0)", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // monitor: compare DUT outputs against the scoreboard on the falling edge
  always @(negedge clk) begin
    rec_t        e;
    logic [16:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, imm_sel,
             alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, trap};
      if (e.chk) begin
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s instr=%h: outputs got=%b want=%b", e.tag, e.instr, got, e.exp);
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 32'(e.cyc) || instret_cnt !== 32'(e.ins)) begin
          failures++;
          $display("FAIL %s counters: got cyc=%0d ins=%0d want cyc=%0d ins=%0d",
                   e.tag, cycle_cnt, instret_cnt, e.cyc, e.ins);
        end
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
